// File: rtl/fnd_axil_slave.sv
// fnd_axil_slave
//   AXI4-Lite responder holding the FND controller's four 32-bit registers and
//   driving a 4-digit multiplexed 7-segment display from them.
//   Register map (addr[3:2]):
//     reg0[0]    display enable
//     reg1[15:0] hex nibble per digit (digit i = bits 4i+3:4i)
//     reg2[3:0]  decimal point per digit
//     reg3       clocks per digit slot (0 behaves as 1)
// Ports
//   s00_axi_aclk / s00_axi_areset : clock, asynchronous active-high reset
//   s00_axi_aw* / w* / b*         : write address, data and response channels
//   s00_axi_ar* / r*              : read address and data channels
//   fnd_com                       : active-low one-hot digit enable, bit0 = rightmost
//   fnd_seg                       : active-low {dp,g,f,e,d,c,b,a}
module fnd_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned SCAN_DIV_RST       = 100000
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic [3:0]                      fnd_com,
    output logic [7:0]                      fnd_seg
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;

    logic          clk;
    logic          rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    // ------------------------------------------------------------------
    // Register file and AXI channel state
    // ------------------------------------------------------------------
    logic [DW-1:0] r_regs [4];

    logic          r_aw_full;
    logic [1:0]    r_aw_sel;
    logic          r_w_full;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_awready;
    logic          r_wready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_ar_hs;
    logic          w_commit;
    logic          w_aw_full_nxt;
    logic          w_w_full_nxt;
    logic          w_bvalid_nxt;
    logic          w_rvalid_nxt;

    assign w_aw_hs  = s00_axi_awvalid & r_awready;
    assign w_w_hs   = s00_axi_wvalid & r_wready;
    assign w_ar_hs  = s00_axi_arvalid & r_arready;
    // Both halves of a write are parked: commit this cycle, respond next.
    assign w_commit = r_aw_full & r_w_full;

    always_comb begin
        w_aw_full_nxt = r_aw_full;
        w_w_full_nxt  = r_w_full;
        w_bvalid_nxt  = r_bvalid;
        w_rvalid_nxt  = r_rvalid;
        if (r_bvalid && s00_axi_bready) begin
            w_bvalid_nxt = 1'b0;
        end
        if (w_commit) begin
            w_aw_full_nxt = 1'b0;
            w_w_full_nxt  = 1'b0;
            w_bvalid_nxt  = 1'b1;
        end else begin
            if (w_aw_hs) w_aw_full_nxt = 1'b1;
            if (w_w_hs)  w_w_full_nxt  = 1'b1;
        end
        if (r_rvalid && s00_axi_rready) begin
            w_rvalid_nxt = 1'b0;
        end
        if (w_ar_hs) begin
            w_rvalid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_aw_sel  <= 2'd0;
            r_w_full  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_aw_full <= w_aw_full_nxt;
            r_w_full  <= w_w_full_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_rvalid  <= w_rvalid_nxt;
            // Readies are registered so they stay low through reset and
            // drop the cycle after their own capture.
            r_awready <= ~w_aw_full_nxt & ~w_bvalid_nxt;
            r_wready  <= ~w_w_full_nxt & ~w_bvalid_nxt;
            r_arready <= ~w_rvalid_nxt;
            if (w_aw_hs) begin
                r_aw_sel <= s00_axi_awaddr[3:2];
            end
            if (w_w_hs) begin
                r_wdata <= s00_axi_wdata;
                r_wstrb <= s00_axi_wstrb;
            end
            // Non-blocking read of r_regs: a same-cycle commit is not visible.
            if (w_ar_hs) begin
                r_rdata <= r_regs[s00_axi_araddr[3:2]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs[0] <= '0;
            r_regs[1] <= '0;
            r_regs[2] <= '0;
            r_regs[3] <= DW'(SCAN_DIV_RST);
        end else if (w_commit) begin
            for (int b = 0; b < SW; b++) begin
                if (r_wstrb[b]) begin
                    r_regs[r_aw_sel][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = 2'b00;
    assign s00_axi_rvalid  = r_rvalid;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [DW-1:0] r_scan_cnt;
    logic [1:0]    r_digit;
    logic [DW-1:0] w_div_max;
    logic [DW-1:0] w_limit;

    assign w_div_max = (r_regs[3] == '0) ? DW'(1) : r_regs[3];
    assign w_limit   = w_div_max - DW'(1);

    // ">=" rather than "==" so lowering reg3 below the count wraps at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd0;
        end else if (r_scan_cnt >= w_limit) begin
            r_scan_cnt <= '0;
            r_digit    <= r_digit + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + DW'(1);
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [3:0] w_nibble;
    logic       w_dp;
    logic [3:0] r_fnd_com;
    logic [7:0] r_fnd_seg;

    always_comb begin
        w_nibble = r_regs[1][3:0];
        w_dp     = r_regs[2][0];
        case (r_digit)
            2'd0:    begin w_nibble = r_regs[1][3:0];   w_dp = r_regs[2][0]; end
            2'd1:    begin w_nibble = r_regs[1][7:4];   w_dp = r_regs[2][1]; end
            2'd2:    begin w_nibble = r_regs[1][11:8];  w_dp = r_regs[2][2]; end
            default: begin w_nibble = r_regs[1][15:12]; w_dp = r_regs[2][3]; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fnd_com <= 4'hF;
            r_fnd_seg <= 8'hFF;
        end else if (r_regs[0][0]) begin
            r_fnd_com <= ~(4'b0001 << r_digit);
            r_fnd_seg <= ~{w_dp, hex7(w_nibble)};
        end else begin
            r_fnd_com <= 4'hF;
            r_fnd_seg <= 8'hFF;
        end
    end

    assign fnd_com = r_fnd_com;
    assign fnd_seg = r_fnd_seg;

    // Protection bits, byte offset and upper register-file bits carry no meaning here.
    logic w_unused;
    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                        s00_axi_araddr[1:0], r_regs[0][DW-1:1], r_regs[1][DW-1:16],
                        r_regs[2][DW-1:4]};

endmodule
